// File: rtl/intra_pkg.sv
// Shared types and default-geometry constants for the intra-prediction write-back path.
// The optional neighbour outputs of mb_writer are enabled with MBW_NEIGHBOR_EN.
package intra_pkg;
    localparam int FRAME_LINES_DEF = 720;
    localparam int FRAME_LEN_DEF   = 1280;
    localparam int MB_ROWS_DEF     = 16;
    localparam int MB_COLS_DEF     = 16;

    localparam int MBS_PER_ROW = FRAME_LEN_DEF / MB_COLS_DEF;
    localparam int MB_TOTAL    = MBS_PER_ROW * (FRAME_LINES_DEF / MB_ROWS_DEF);
    localparam int N           = MB_ROWS_DEF * MB_COLS_DEF;

    typedef logic [7:0]        pix_t;
    typedef logic signed [8:0] resid_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } mbw_state_t;
endpackage

// File: rtl/mb_writer_if.sv
// Macroblock input handshake plus frame-memory write port of mb_writer.
// Neighbour outputs exist only when MBW_NEIGHBOR_EN is defined.
interface mb_writer_if
    import intra_pkg::*;
#(
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16,
    parameter int ADDR_W    = 20
);
    localparam int NPIX = MB_SIZE_L * MB_SIZE_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [12:0]           mbnumber;
    pix_t   [NPIX-1:0]     pred;
    resid_t [NPIX-1:0]     resid;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    pix_t                  wr_data;
    logic                  done;
    logic                  err;
`ifdef MBW_NEIGHBOR_EN
    pix_t [MB_SIZE_W-1:0]  nb_top;
    pix_t [MB_SIZE_L-1:0]  nb_left;
    logic                  nb_valid;
`endif

    modport slave (
        input  in_valid, mbnumber, pred, resid,
        output in_ready, wr_en, wr_addr, wr_data, done, err
`ifdef MBW_NEIGHBOR_EN
        , output nb_top, nb_left, nb_valid
`endif
    );

    modport master (
        output in_valid, mbnumber, pred, resid,
        input  in_ready, wr_en, wr_addr, wr_data, done, err
`ifdef MBW_NEIGHBOR_EN
        , input nb_top, nb_left, nb_valid
`endif
    );
endinterface

// File: rtl/recon_clip.sv
// Reconstructs one pixel: pred + resid saturated to the 0..255 pixel range.
module recon_clip
    import intra_pkg::*;
(
    input  pix_t   pred,
    input  resid_t resid,
    output pix_t   pix
);
    logic signed [9:0] sum;

    // Range is -256..510, so bit 9 flags negative and bit 8 flags overflow.
    always_comb begin
        sum = $signed({2'b00, pred}) + $signed({resid[8], resid});
        if (sum[9])
            pix = 8'd0;
        else if (sum[8])
            pix = 8'd255;
        else
            pix = sum[7:0];
    end
endmodule

// File: rtl/mb_writer.sv
// Captures a clipped macroblock and writes it raster-order into the frame memory.
// Define MBW_NEIGHBOR_EN to also export the last row/column as neighbour pixels.
module mb_writer
    import intra_pkg::*;
#(
    parameter int WIDTH     = 720,
    parameter int LENGTH    = 1280,
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16,
    parameter int ADDR_W    = 20
)
(
    input  logic       clk,
    input  logic       reset,
    mb_writer_if.slave bus
);
    localparam int NPIX    = MB_SIZE_L * MB_SIZE_W;
    localparam int MBS_ROW = LENGTH / MB_SIZE_W;
    localparam int MB_CNT  = MBS_ROW * (WIDTH / MB_SIZE_L);
    localparam int IW      = $clog2(NPIX);
    localparam int JW      = $clog2(MB_SIZE_L);
    localparam int KW      = $clog2(MB_SIZE_W);

    mbw_state_t        state_reg, state_next;
    pix_t              clip_pix [NPIX];
    pix_t              pix_reg  [NPIX];
    logic              in_ready_reg, wr_en_reg, done_reg, err_reg, err_pending_reg;
    logic [ADDR_W-1:0] wr_addr_reg, addr_reg, row_base_reg;
    pix_t              wr_data_reg;
    logic [JW-1:0]     j_reg;
    logic [KW-1:0]     k_reg;
    logic [IW-1:0]     idx_reg;
    logic              accept, in_range, last_pix;

    function automatic logic [ADDR_W-1:0] base_of(input logic [12:0] mbn);
        int mb_x, mb_y;
        mb_x = int'(mbn) % MBS_ROW;
        mb_y = int'(mbn) / MBS_ROW;
        return ADDR_W'(mb_y * MB_SIZE_L * LENGTH + mb_x * MB_SIZE_W);
    endfunction

    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_clip
            recon_clip u_clip (
                .pred  (bus.pred[gi]),
                .resid (bus.resid[gi]),
                .pix   (clip_pix[gi])
            );
        end
    endgenerate

    assign accept   = (state_reg == ST_IDLE) && in_ready_reg && bus.in_valid;
    assign in_range = int'(bus.mbnumber) < MB_CNT;
    assign last_pix = (j_reg == JW'(MB_SIZE_L - 1)) && (k_reg == KW'(MB_SIZE_W - 1));

    always_ff @(posedge clk) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (accept) state_next = in_range ? ST_WRITE : ST_DONE;
            ST_WRITE: if (last_pix) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Pixel store has no reset: it is always loaded before being read.
    always_ff @(posedge clk) begin
        if (accept)
            pix_reg <= clip_pix;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready_reg    <= 1'b1;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            err_pending_reg <= 1'b0;
            addr_reg        <= '0;
            row_base_reg    <= '0;
            j_reg           <= '0;
            k_reg           <= '0;
            idx_reg         <= '0;
        end else begin
            wr_en_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            // Ready only after a full cycle back in IDLE, so a pending producer
            // cannot be accepted during the done pulse.
            in_ready_reg <= (state_reg == ST_IDLE) && (state_next == ST_IDLE);
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        err_pending_reg <= !in_range;
                        addr_reg        <= base_of(bus.mbnumber);
                        row_base_reg    <= base_of(bus.mbnumber);
                        j_reg           <= '0;
                        k_reg           <= '0;
                        idx_reg         <= '0;
                    end
                end
                ST_WRITE: begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= addr_reg;
                    wr_data_reg <= pix_reg[idx_reg];
                    idx_reg     <= idx_reg + IW'(1);
                    if (k_reg == KW'(MB_SIZE_W - 1)) begin
                        k_reg        <= '0;
                        j_reg        <= j_reg + JW'(1);
                        row_base_reg <= row_base_reg + ADDR_W'(LENGTH);
                        addr_reg     <= row_base_reg + ADDR_W'(LENGTH);
                    end else begin
                        k_reg    <= k_reg + KW'(1);
                        addr_reg <= addr_reg + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    done_reg <= 1'b1;
                    err_reg  <= err_pending_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = in_ready_reg;
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;

`ifdef MBW_NEIGHBOR_EN
    pix_t nb_top_reg  [MB_SIZE_W];
    pix_t nb_left_reg [MB_SIZE_L];
    logic nb_valid_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            nb_valid_reg <= 1'b0;
            for (int i = 0; i < MB_SIZE_W; i++) nb_top_reg[i]  <= '0;
            for (int i = 0; i < MB_SIZE_L; i++) nb_left_reg[i] <= '0;
        end else begin
            if (accept)
                nb_valid_reg <= 1'b0;
            else if (state_reg == ST_DONE && !err_pending_reg)
                nb_valid_reg <= 1'b1;
            if (state_reg == ST_WRITE) begin
                if (j_reg == JW'(MB_SIZE_L - 1)) nb_top_reg[k_reg]  <= pix_reg[idx_reg];
                if (k_reg == KW'(MB_SIZE_W - 1)) nb_left_reg[j_reg] <= pix_reg[idx_reg];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MB_SIZE_W; gi++) begin : g_nb_top
            assign bus.nb_top[gi] = nb_top_reg[gi];
        end
        for (genvar gi = 0; gi < MB_SIZE_L; gi++) begin : g_nb_left
            assign bus.nb_left[gi] = nb_left_reg[gi];
        end
    endgenerate

    assign bus.nb_valid = nb_valid_reg;
`endif
endmodule

// File: tb/tb_mb_writer.sv
// Directed, table-driven bench for mb_writer: addresses, clipping, timing, reset and hold.
// Neighbour checks are compiled in when MBW_NEIGHBOR_EN is defined.
module tb_mb_writer;
    import intra_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mb_writer_if #(.MB_SIZE_L(16), .MB_SIZE_W(16), .ADDR_W(20)) bus ();

    mb_writer #(
        .WIDTH(720), .LENGTH(1280), .MB_SIZE_L(16), .MB_SIZE_W(16), .ADDR_W(20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int mb;
        bit ramp;       // pred = pixel index, resid = 0
        int pv;
        int rv;
        int exp_first;  // -1 when no writes are expected
        int exp_last;
        int exp_data;   // ignored for ramp vectors (expected = pixel index)
        bit exp_err;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int base_of(input int mbn);
        return (mbn / 80) * 16 * 1280 + (mbn % 80) * 16;
    endfunction

    task automatic load_mb(input int mb, input bit ramp, input int pv, input int rv);
        bus.mbnumber = 13'(mb);
        for (int i = 0; i < 256; i++) begin
            bus.pred[i]  = ramp ? 8'(i) : 8'(pv);
            bus.resid[i] = ramp ? 9'(0) : 9'(rv);
        end
    endtask

    // Raise in_valid and return the cycle number of the accepting edge.
    task automatic handshake(input bit hold, output int e0);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            $display("FAIL handshake: in_ready stuck at 0 after %0d cycles", n);
            $fatal(1, "handshake timeout");
        end
        @(posedge clk);
        #1;
        e0 = cyc;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Observe one macroblock from the cycle after the accept edge until in_ready returns.
    task automatic watch(input vec_t v, input string tag);
        int nw, first, last, aerr, derr, gap, done_t, ndone, err_at, stray_err, ready_t;
        int nb_early, nb_at_done;
        nw = 0; first = -1; last = -1; aerr = 0; derr = 0; gap = 0;
        done_t = -1; ndone = 0; err_at = 0; stray_err = 0; ready_t = -1;
        nb_early = 0; nb_at_done = 0;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk);
            #1;
            if (bus.wr_en) begin
                int expa, expd;
                expa = base_of(v.mb) + (nw / 16) * 1280 + (nw % 16);
                expd = v.ramp ? nw : v.exp_data;
                if (nw == 0) first = int'(bus.wr_addr);
                last = int'(bus.wr_addr);
                if (int'(bus.wr_addr) != expa) aerr++;
                if (int'(bus.wr_data) != expd) derr++;
                if (t != nw + 1) gap++;
                nw++;
            end
            if (bus.done) begin
                ndone++;
                done_t = t;
                err_at = int'(bus.err);
`ifdef MBW_NEIGHBOR_EN
                nb_at_done = int'(bus.nb_valid);
`endif
            end else if (bus.err) begin
                stray_err++;
            end
`ifdef MBW_NEIGHBOR_EN
            if (!bus.done && ndone == 0 && bus.nb_valid) nb_early++;
`endif
            if (bus.in_ready) begin
                ready_t = t;
                break;
            end
        end
        check({tag, " write count"}, nw, v.exp_err ? 0 : 256);
        check({tag, " first addr"}, first, v.exp_first);
        check({tag, " last addr"}, last, v.exp_last);
        check({tag, " addr errors"}, aerr, 0);
        check({tag, " data errors"}, derr, 0);
        check({tag, " write gaps"}, gap, 0);
        check({tag, " done cycle"}, done_t, v.exp_err ? 1 : 257);
        check({tag, " done count"}, ndone, 1);
        check({tag, " err at done"}, err_at, v.exp_err ? 1 : 0);
        check({tag, " err outside done"}, stray_err, 0);
        check({tag, " in_ready cycle"}, ready_t, v.exp_err ? 2 : 258);
`ifdef MBW_NEIGHBOR_EN
        check({tag, " nb_valid before done"}, nb_early, 0);
        check({tag, " nb_valid at done"}, nb_at_done, v.exp_err ? 0 : 1);
`endif
    endtask

    vec_t vecs [9];

    initial begin
        int e0, e0b, bad, wen_seen, done_seen;

        vecs[0] = '{mb: 0,    ramp: 0, pv: 100, rv: 0,    exp_first: 0,      exp_last: 19215,  exp_data: 100, exp_err: 0};
        vecs[1] = '{mb: 1,    ramp: 0, pv: 250, rv: 20,   exp_first: 16,     exp_last: 19231,  exp_data: 255, exp_err: 0};
        vecs[2] = '{mb: 2,    ramp: 0, pv: 5,   rv: -20,  exp_first: 32,     exp_last: 19247,  exp_data: 0,   exp_err: 0};
        vecs[3] = '{mb: 3,    ramp: 0, pv: 255, rv: -256, exp_first: 48,     exp_last: 19263,  exp_data: 0,   exp_err: 0};
        vecs[4] = '{mb: 81,   ramp: 0, pv: 128, rv: -1,   exp_first: 20496,  exp_last: 39711,  exp_data: 127, exp_err: 0};
        vecs[5] = '{mb: 3599, ramp: 0, pv: 0,   rv: 255,  exp_first: 902384, exp_last: 921599, exp_data: 255, exp_err: 0};
        vecs[6] = '{mb: 3600, ramp: 0, pv: 100, rv: 0,    exp_first: -1,     exp_last: -1,     exp_data: 0,   exp_err: 1};
        vecs[7] = '{mb: 4,    ramp: 0, pv: 255, rv: 255,  exp_first: 64,     exp_last: 19279,  exp_data: 255, exp_err: 0};
        vecs[8] = '{mb: 5,    ramp: 1, pv: 0,   rv: 0,    exp_first: 80,     exp_last: 19295,  exp_data: 0,   exp_err: 0};

        reset = 1'b0;
        bus.in_valid = 1'b0;
        load_mb(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 1);
        check("reset wr_en", bus.wr_en, 0);
        check("reset wr_addr", bus.wr_addr, 0);
        check("reset wr_data", bus.wr_data, 0);
        check("reset done", bus.done, 0);
        check("reset err", bus.err, 0);
`ifdef MBW_NEIGHBOR_EN
        check("reset nb_valid", bus.nb_valid, 0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            load_mb(vecs[i].mb, vecs[i].ramp, vecs[i].pv, vecs[i].rv);
            handshake(1'b0, e0);
            watch(vecs[i], $sformatf("vec%0d mb%0d", i, vecs[i].mb));
`ifdef MBW_NEIGHBOR_EN
            if (vecs[i].ramp) begin
                bad = 0;
                for (int k = 0; k < 16; k++)
                    if (int'(bus.nb_top[k]) != 240 + k) bad++;
                check("ramp nb_top errors", bad, 0);
                bad = 0;
                for (int j = 0; j < 16; j++)
                    if (int'(bus.nb_left[j]) != 16 * j + 15) bad++;
                check("ramp nb_left errors", bad, 0);
                check("ramp nb_valid held", bus.nb_valid, 1);
            end
`endif
        end

        // Reset during write 100 abandons the macroblock.
        load_mb(10, 0, 50, 0);
        handshake(1'b0, e0);
        repeat (101) @(posedge clk);
        #1;
        check("midreset write100 wr_en", bus.wr_en, 1);
        check("midreset write100 addr", bus.wr_addr, base_of(10) + 6 * 1280 + 4);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset wr_en after edge", bus.wr_en, 0);
        check("midreset in_ready after edge", bus.in_ready, 1);
        check("midreset wr_addr after edge", bus.wr_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wen_seen = 0;
        done_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            wen_seen += int'(bus.wr_en);
            done_seen += int'(bus.done);
        end
        check("midreset stray wr_en", wen_seen, 0);
        check("midreset stray done", done_seen, 0);
        check("midreset in_ready after release", bus.in_ready, 1);
`ifdef MBW_NEIGHBOR_EN
        check("midreset nb_valid", bus.nb_valid, 0);
`endif
        load_mb(0, 0, 9, 0);
        handshake(1'b0, e0);
        watch('{mb: 0, ramp: 0, pv: 9, rv: 0, exp_first: 0, exp_last: 19215, exp_data: 9, exp_err: 0},
              "after reset mb0");

        // in_valid held through WRITE and done; inputs change right after accept.
        load_mb(7, 0, 60, 0);
        handshake(1'b1, e0);
        load_mb(8, 0, 7, 0);
        watch('{mb: 7, ramp: 0, pv: 60, rv: 0, exp_first: 112, exp_last: 19327, exp_data: 60, exp_err: 0},
              "hold first mb7");
        handshake(1'b0, e0b);
        check("hold accept spacing", e0b - e0, 259);
        watch('{mb: 8, ramp: 0, pv: 7, rv: 0, exp_first: 128, exp_last: 19343, exp_data: 7, exp_err: 0},
              "hold second mb8");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
